// File: rtl/packet_width_downconverter.sv
// ---------------------------------------------------------------------------
// packet_width_downconverter
//
// Splits each wide streaming input beat into narrow output slices, carrying
// packet markers (SOP/EOP), the trailing-empty count and the channel
// sideband. One beat is buffered at a time. The input is ready again in the
// same cycle the last slice of the buffered beat is taken, so consecutive
// beats stream with no idle cycle between them.
//
// Ports
//   clock_clk, reset_reset          clock; asynchronous active-high reset
//   asi_in0_*                       wide input stream (data, valid, ready,
//                                   startofpacket, endofpacket, empty,
//                                   channel)
//   aso_out0_*                      narrow output stream (data, valid,
//                                   ready, startofpacket, endofpacket,
//                                   channel)
//   stat_pkt_count                  packets completed at the output, wraps
//   stat_err_framing                one-cycle pulse on a framing error
//
// FSM states
//   state        | meaning
//   -------------+---------------------------------------------------------
//   ST_EMPTY     | buffer holds no data; input is ready
//   ST_SERIALISE | buffer holds a beat with at least one slice left to emit
// ---------------------------------------------------------------------------
module packet_width_downconverter #(
    parameter int IN_WIDTH      = 256,
    parameter int OUT_WIDTH     = 32,
    parameter int BIG_ENDIAN    = 1,
    parameter int CHANNEL_WIDTH = 4
) (
    input  logic                                  clock_clk,
    input  logic                                  reset_reset,
    input  logic [IN_WIDTH-1:0]                   asi_in0_data,
    input  logic                                  asi_in0_valid,
    output logic                                  asi_in0_ready,
    input  logic                                  asi_in0_startofpacket,
    input  logic                                  asi_in0_endofpacket,
    input  logic [$clog2(IN_WIDTH/OUT_WIDTH)-1:0] asi_in0_empty,
    input  logic [CHANNEL_WIDTH-1:0]              asi_in0_channel,
    output logic [OUT_WIDTH-1:0]                  aso_out0_data,
    output logic                                  aso_out0_valid,
    input  logic                                  aso_out0_ready,
    output logic                                  aso_out0_startofpacket,
    output logic                                  aso_out0_endofpacket,
    output logic [CHANNEL_WIDTH-1:0]              aso_out0_channel,
    output logic [15:0]                           stat_pkt_count,
    output logic                                  stat_err_framing
);

    localparam int RATIO       = IN_WIDTH / OUT_WIDTH;
    localparam int EMPTY_WIDTH = $clog2(RATIO);

    localparam logic [EMPTY_WIDTH-1:0] MAX_IDX     = EMPTY_WIDTH'(RATIO - 1);
    localparam logic [EMPTY_WIDTH:0]   MAX_IDX_EXT = (EMPTY_WIDTH + 1)'(RATIO - 1);

    generate
        if ((IN_WIDTH % OUT_WIDTH) != 0 || (IN_WIDTH / OUT_WIDTH) < 2) begin : g_bad_params
            $error("packet_width_downconverter: IN_WIDTH must be a multiple of OUT_WIDTH with a ratio of at least 2");
        end
    endgenerate

    typedef enum logic {
        ST_EMPTY     = 1'b0,
        ST_SERIALISE = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [IN_WIDTH-1:0]      buffer;
    logic [EMPTY_WIDTH-1:0]   idx;
    logic [EMPTY_WIDTH-1:0]   last_idx;
    logic                     sop_q;
    logic                     eop_q;
    logic [CHANNEL_WIDTH-1:0] chan_q;
    logic                     in_packet;

    logic                     in_fire;
    logic                     out_fire;
    logic                     last_slice;
    logic                     load_beat;
    logic                     frame_err;

    logic [EMPTY_WIDTH:0]     empty_ext;
    logic [EMPTY_WIDTH-1:0]   empty_eff;
    logic [EMPTY_WIDTH-1:0]   last_idx_nxt;

    logic [OUT_WIDTH-1:0]     slice_arr [RATIO];

    // Slice i of the buffered beat, in emission order.
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
        if (BIG_ENDIAN != 0) begin : g_be
            assign slice_arr[gi] = buffer[IN_WIDTH-1-gi*OUT_WIDTH -: OUT_WIDTH];
        end else begin : g_le
            assign slice_arr[gi] = buffer[gi*OUT_WIDTH +: OUT_WIDTH];
        end
    end

    assign in_fire    = asi_in0_valid && asi_in0_ready;
    assign out_fire   = aso_out0_valid && aso_out0_ready;
    assign last_slice = (idx == last_idx);

    // A beat without SOP outside a packet is swallowed; an SOP inside a
    // packet is flagged but still starts the new packet.
    assign load_beat = in_fire && (asi_in0_startofpacket || in_packet);
    assign frame_err = in_fire && ((!asi_in0_startofpacket && !in_packet) ||
                                   (asi_in0_startofpacket && in_packet));

    // Empty only matters on EOP beats; values past the last slice still
    // leave one slice to emit.
    assign empty_ext    = {1'b0, asi_in0_empty};
    assign empty_eff    = (empty_ext > MAX_IDX_EXT) ? MAX_IDX : asi_in0_empty;
    assign last_idx_nxt = asi_in0_endofpacket ? (MAX_IDX - empty_eff) : MAX_IDX;

    // State register
    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: begin
                if (load_beat) begin
                    state_nxt = ST_SERIALISE;
                end
            end
            ST_SERIALISE: begin
                if (out_fire && last_slice && !load_beat) begin
                    state_nxt = ST_EMPTY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // Output logic
    always_comb begin
        asi_in0_ready          = 1'b0;
        aso_out0_valid         = 1'b0;
        aso_out0_startofpacket = 1'b0;
        aso_out0_endofpacket   = 1'b0;
        aso_out0_data          = slice_arr[idx];
        aso_out0_channel       = chan_q;
        case (state)
            ST_EMPTY: begin
                asi_in0_ready = 1'b1;
            end
            ST_SERIALISE: begin
                aso_out0_valid         = 1'b1;
                aso_out0_startofpacket = sop_q && (idx == '0);
                aso_out0_endofpacket   = eop_q && last_slice;
                asi_in0_ready          = aso_out0_ready && last_slice;
            end
            default: begin
                asi_in0_ready = 1'b0;
            end
        endcase
    end

    // Beat buffer, slice index, packet tracking and statistics
    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            buffer           <= '0;
            idx              <= '0;
            last_idx         <= '0;
            sop_q            <= 1'b0;
            eop_q            <= 1'b0;
            chan_q           <= '0;
            in_packet        <= 1'b0;
            stat_pkt_count   <= '0;
            stat_err_framing <= 1'b0;
        end else begin
            stat_err_framing <= frame_err;
            if (out_fire && aso_out0_endofpacket) begin
                stat_pkt_count <= stat_pkt_count + 16'd1;
            end
            if (load_beat) begin
                buffer    <= asi_in0_data;
                idx       <= '0;
                last_idx  <= last_idx_nxt;
                sop_q     <= asi_in0_startofpacket;
                eop_q     <= asi_in0_endofpacket;
                chan_q    <= asi_in0_channel;
                // A loaded beat either opens or continues a packet, so the
                // only way out is its EOP.
                in_packet <= !asi_in0_endofpacket;
            end else if (out_fire && !last_slice) begin
                idx <= idx + EMPTY_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_packet_width_downconverter.sv
module tb_packet_width_downconverter;

    localparam int IN_W  = 256;
    localparam int OUT_W = 32;
    localparam int RATIO = 8;
    localparam int EW    = 3;
    localparam int CW    = 4;

    typedef struct {
        logic [OUT_W-1:0] d;
        logic             s;
        logic             e;
        logic [CW-1:0]    c;
        int               cyc;
    } slice_t;

    logic             clock_clk = 1'b0;
    logic             reset_reset = 1'b1;
    logic [IN_W-1:0]  in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_sop = 1'b0;
    logic             in_eop = 1'b0;
    logic [EW-1:0]    in_empty = '0;
    logic [CW-1:0]    in_chan = '0;
    logic             out_ready = 1'b1;

    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid, out_sop, out_eop;
    logic [CW-1:0]    out_chan;
    logic [15:0]      pkt_count;
    logic             err;

    logic             le_in_ready;
    logic [OUT_W-1:0] le_data;
    logic             le_valid, le_sop, le_eop;
    logic [CW-1:0]    le_chan;
    logic [15:0]      le_pkt_count;
    logic             le_err;

    packet_width_downconverter #(
        .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .BIG_ENDIAN(1), .CHANNEL_WIDTH(CW)
    ) dut (
        .clock_clk(clock_clk), .reset_reset(reset_reset),
        .asi_in0_data(in_data), .asi_in0_valid(in_valid), .asi_in0_ready(in_ready),
        .asi_in0_startofpacket(in_sop), .asi_in0_endofpacket(in_eop),
        .asi_in0_empty(in_empty), .asi_in0_channel(in_chan),
        .aso_out0_data(out_data), .aso_out0_valid(out_valid), .aso_out0_ready(out_ready),
        .aso_out0_startofpacket(out_sop), .aso_out0_endofpacket(out_eop),
        .aso_out0_channel(out_chan), .stat_pkt_count(pkt_count), .stat_err_framing(err)
    );

    packet_width_downconverter #(
        .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .BIG_ENDIAN(0), .CHANNEL_WIDTH(CW)
    ) dut_le (
        .clock_clk(clock_clk), .reset_reset(reset_reset),
        .asi_in0_data(in_data), .asi_in0_valid(in_valid), .asi_in0_ready(le_in_ready),
        .asi_in0_startofpacket(in_sop), .asi_in0_endofpacket(in_eop),
        .asi_in0_empty(in_empty), .asi_in0_channel(in_chan),
        .aso_out0_data(le_data), .aso_out0_valid(le_valid), .aso_out0_ready(out_ready),
        .aso_out0_startofpacket(le_sop), .aso_out0_endofpacket(le_eop),
        .aso_out0_channel(le_chan), .stat_pkt_count(le_pkt_count), .stat_err_framing(le_err)
    );

    always #5 clock_clk = ~clock_clk;

    // ---------------- monitor (records only) ----------------
    int     cyc = 0;
    int     valid_cycles = 0;
    int     rdy_busy_cycles = 0;
    int     err_cycles = 0;
    int     stall_viol = 0;
    logic   hold_v = 1'b0;
    slice_t hold;
    slice_t obs_q[$];
    slice_t le_q[$];

    always @(posedge clock_clk) cyc <= cyc + 1;

    always @(negedge clock_clk) begin
        if (reset_reset) begin
            hold_v <= 1'b0;
        end else begin
            if (out_valid) valid_cycles <= valid_cycles + 1;
            if (in_ready && out_valid) rdy_busy_cycles <= rdy_busy_cycles + 1;
            if (err) err_cycles <= err_cycles + 1;
            if (hold_v && (out_valid !== 1'b1 || out_data !== hold.d || out_sop !== hold.s ||
                           out_eop !== hold.e || out_chan !== hold.c))
                stall_viol <= stall_viol + 1;
            hold_v <= out_valid && !out_ready;
            hold   <= '{out_data, out_sop, out_eop, out_chan, cyc};
            if (out_valid && out_ready) obs_q.push_back('{out_data, out_sop, out_eop, out_chan, cyc});
            if (le_valid && out_ready) le_q.push_back('{le_data, le_sop, le_eop, le_chan, cyc});
        end
    end

    // ---------------- reference model ----------------
    int     checks = 0;
    int     errors = 0;
    int     last_acc = 0;
    bit     m_in_pkt = 0;
    int     m_err = 0;
    int     m_pkts = 0;
    slice_t exp_q[$];
    slice_t exp_le_q[$];

    // Packet-level view: a beat yields RATIO slices minus its (clamped)
    // empty count on EOP, ordered MS-first or LS-first.
    function automatic void model_beat(input logic [IN_W-1:0] d, input logic s, input logic e,
                                       input logic [EW-1:0] emp, input logic [CW-1:0] ch);
        int n;
        int k;
        logic [IN_W-1:0] sh;
        slice_t x;
        if (!s && !m_in_pkt) begin
            m_err++;
            return;
        end
        if (s && m_in_pkt) m_err++;
        k = (int'(emp) > RATIO - 1) ? RATIO - 1 : int'(emp);
        n = e ? RATIO - k : RATIO;
        for (int i = 0; i < n; i++) begin
            x.s = s && (i == 0);
            x.e = e && (i == n - 1);
            x.c = ch;
            x.cyc = 0;
            sh = d >> ((RATIO - 1 - i) * OUT_W);
            x.d = sh[OUT_W-1:0];
            exp_q.push_back(x);
            sh = d >> (i * OUT_W);
            x.d = sh[OUT_W-1:0];
            exp_le_q.push_back(x);
        end
        if (e) m_pkts++;
        if (s) m_in_pkt = 1'b1;
        if (e) m_in_pkt = 1'b0;
    endfunction

    // ---------------- drivers ----------------
    task automatic do_reset();
        reset_reset = 1'b1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        in_data = '0; in_empty = '0; in_chan = '0;
        repeat (3) @(posedge clock_clk);
        @(negedge clock_clk);
        reset_reset = 1'b0;
        @(posedge clock_clk); #1;
        m_in_pkt = 1'b0; m_pkts = 0;
        exp_q.delete(); exp_le_q.delete();
    endtask

    task automatic send_beat(input logic [IN_W-1:0] d, input logic s, input logic e,
                             input logic [EW-1:0] emp, input logic [CW-1:0] ch);
        int n;
        in_data = d; in_sop = s; in_eop = e; in_empty = emp; in_chan = ch; in_valid = 1'b1;
        n = 0;
        @(negedge clock_clk);
        while (in_ready !== 1'b1 && n < 300) begin
            @(negedge clock_clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_beat_ready got %b exp 1 after %0d cycles", in_ready, n);
        end
        @(posedge clock_clk); #1;
        last_acc = cyc;
        model_beat(d, s, e, emp, ch);
    endtask

    task automatic in_idle();
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock_clk);
        while (out_valid !== 1'b0 && n < 500) begin
            @(negedge clock_clk);
            n++;
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle got valid %b exp 0", out_valid);
        end
        @(posedge clock_clk); #1;
    endtask

    function automatic logic [IN_W-1:0] rand_beat();
        logic [IN_W-1:0] d;
        for (int w = 0; w < RATIO; w++) d[w*OUT_W +: OUT_W] = $urandom;
        return d;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        @(negedge clock_clk);
        checks += 8;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        if (out_data !== '0) begin errors++; $display("FAIL rst_out_data got %h exp 0", out_data); end
        if (out_sop !== 1'b0) begin errors++; $display("FAIL rst_out_sop got %b exp 0", out_sop); end
        if (out_eop !== 1'b0) begin errors++; $display("FAIL rst_out_eop got %b exp 0", out_eop); end
        if (out_chan !== '0) begin errors++; $display("FAIL rst_out_chan got %h exp 0", out_chan); end
        if (pkt_count !== 16'd0) begin errors++; $display("FAIL rst_pkt_count got %0d exp 0", pkt_count); end
        if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
        @(posedge clock_clk); #1;
    endtask

    task automatic test_single_beat();
        logic [IN_W-1:0] d;
        int base;
        int lbase;
        for (int j = 0; j < RATIO; j++) d[j*OUT_W +: OUT_W] = j;
        base = obs_q.size();
        lbase = le_q.size();
        send_beat(d, 1'b1, 1'b1, 3'd0, 4'hA);
        in_idle();
        wait_idle();
        checks += 4;
        if (obs_q.size() - base != 8) begin
            errors++; $display("FAIL single_count got %0d exp 8", obs_q.size() - base);
        end else begin
            if (obs_q[base].cyc != last_acc) begin
                errors++; $display("FAIL single_latency got cyc %0d exp %0d", obs_q[base].cyc, last_acc);
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs_q[base+i].d !== OUT_W'(7 - i) || obs_q[base+i].s !== (i == 0) ||
                    obs_q[base+i].e !== (i == 7) || obs_q[base+i].c !== 4'hA) begin
                    errors++;
                    $display("FAIL single_slice[%0d] got %h/%b/%b/%h exp %h/%b/%b/a", i, obs_q[base+i].d,
                             obs_q[base+i].s, obs_q[base+i].e, obs_q[base+i].c, 7 - i, i == 0, i == 7);
                end
            end
        end
        if (le_q.size() - lbase != 8) begin
            errors++; $display("FAIL le_count got %0d exp 8", le_q.size() - lbase);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (le_q[lbase+i].d !== OUT_W'(i) || le_q[lbase+i].s !== (i == 0) || le_q[lbase+i].e !== (i == 7)) begin
                    errors++;
                    $display("FAIL le_slice[%0d] got %h/%b/%b exp %h", i, le_q[lbase+i].d, le_q[lbase+i].s, le_q[lbase+i].e, i);
                end
            end
        end
        if (pkt_count !== 16'd1) begin errors++; $display("FAIL single_pkt_count got %0d exp 1", pkt_count); end
        if (stall_viol != 0) begin errors++; $display("FAIL single_stall_viol got %0d exp 0", stall_viol); end
    endtask

    task automatic test_empty();
        logic [IN_W-1:0] d;
        int base;
        int n_exp;
        logic [EW-1:0] emps [2];
        emps[0] = 3'd5;
        emps[1] = 3'd7;
        for (int t = 0; t < 2; t++) begin
            d = rand_beat();
            n_exp = (t == 0) ? 3 : 1;
            base = obs_q.size();
            send_beat(d, 1'b1, 1'b1, emps[t], 4'(t + 5));
            in_idle();
            wait_idle();
            checks++;
            if (obs_q.size() - base != n_exp) begin
                errors++; $display("FAIL empty%0d_count got %0d exp %0d", emps[t], obs_q.size() - base, n_exp);
            end else begin
                for (int i = 0; i < n_exp; i++) begin
                    checks++;
                    if (obs_q[base+i].d !== d[IN_W-1-i*OUT_W -: OUT_W] || obs_q[base+i].s !== (i == 0) ||
                        obs_q[base+i].e !== (i == n_exp - 1) || obs_q[base+i].c !== 4'(t + 5)) begin
                        errors++;
                        $display("FAIL empty%0d_slice[%0d] got %h/%b/%b exp %h/%b/%b", emps[t], i, obs_q[base+i].d,
                                 obs_q[base+i].s, obs_q[base+i].e, d[IN_W-1-i*OUT_W -: OUT_W], i == 0, i == n_exp - 1);
                    end
                end
            end
        end
        checks++;
        if (pkt_count !== 16'd3) begin errors++; $display("FAIL empty_pkt_count got %0d exp 3", pkt_count); end
    endtask

    task automatic test_back_to_back();
        int base;
        int v0;
        int r0;
        exp_q.delete(); exp_le_q.delete();
        base = obs_q.size();
        v0 = valid_cycles;
        r0 = rdy_busy_cycles;
        send_beat(rand_beat(), 1'b1, 1'b0, 3'd0, 4'h3);
        send_beat(rand_beat(), 1'b0, 1'b0, 3'd3, 4'h3);
        send_beat(rand_beat(), 1'b0, 1'b1, 3'd0, 4'h3);
        in_idle();
        wait_idle();
        checks += 4;
        if (valid_cycles - v0 != 24) begin errors++; $display("FAIL b2b_valid_cycles got %0d exp 24", valid_cycles - v0); end
        if (rdy_busy_cycles - r0 != 3) begin errors++; $display("FAIL b2b_ready_pulses got %0d exp 3", rdy_busy_cycles - r0); end
        if (obs_q.size() - base != exp_q.size()) begin
            errors++; $display("FAIL b2b_count got %0d exp %0d", obs_q.size() - base, exp_q.size());
        end else begin
            if (obs_q[base+23].cyc - obs_q[base].cyc != 23) begin
                errors++; $display("FAIL b2b_span got %0d exp 23", obs_q[base+23].cyc - obs_q[base].cyc);
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[base+i].d !== exp_q[i].d || obs_q[base+i].s !== exp_q[i].s ||
                    obs_q[base+i].e !== exp_q[i].e || obs_q[base+i].c !== exp_q[i].c) begin
                    errors++;
                    $display("FAIL b2b_slice[%0d] got %h/%b/%b exp %h/%b/%b", i, obs_q[base+i].d, obs_q[base+i].s,
                             obs_q[base+i].e, exp_q[i].d, exp_q[i].s, exp_q[i].e);
                end
            end
        end
    endtask

    task automatic test_stall();
        int base;
        int v0;
        int s0;
        logic [IN_W-1:0] d;
        d = rand_beat();
        exp_q.delete(); exp_le_q.delete();
        base = obs_q.size();
        v0 = valid_cycles;
        s0 = stall_viol;
        out_ready = 1'b1;
        fork
            begin
                send_beat(d, 1'b1, 1'b1, 3'd0, 4'h6);
                in_idle();
            end
            begin
                repeat (18) begin
                    @(posedge clock_clk); #1;
                    out_ready = ~out_ready;
                end
            end
        join
        out_ready = 1'b1;
        wait_idle();
        checks += 3;
        if (valid_cycles - v0 != 16) begin errors++; $display("FAIL stall_valid_cycles got %0d exp 16", valid_cycles - v0); end
        if (stall_viol - s0 != 0) begin errors++; $display("FAIL stall_stability got %0d exp 0", stall_viol - s0); end
        if (obs_q.size() - base != 8) begin
            errors++; $display("FAIL stall_count got %0d exp 8", obs_q.size() - base);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs_q[base+i].d !== d[IN_W-1-i*OUT_W -: OUT_W] || obs_q[base+i].cyc != last_acc + 1 + 2 * i) begin
                    errors++;
                    $display("FAIL stall_slice[%0d] got %h@%0d exp %h@%0d", i, obs_q[base+i].d, obs_q[base+i].cyc,
                             d[IN_W-1-i*OUT_W -: OUT_W], last_acc + 1 + 2 * i);
                end
            end
        end
    endtask

    task automatic test_framing();
        int base;
        int e0;
        do_reset();
        base = obs_q.size();
        e0 = err_cycles;
        send_beat(rand_beat(), 1'b0, 1'b0, 3'd0, 4'h1);
        in_idle();
        repeat (12) @(posedge clock_clk);
        #1;
        checks += 2;
        if (obs_q.size() != base) begin errors++; $display("FAIL frame_discard got %0d slices exp 0", obs_q.size() - base); end
        if (err_cycles - e0 != 1) begin errors++; $display("FAIL frame_err_pulse got %0d cycles exp 1", err_cycles - e0); end
        exp_q.delete(); exp_le_q.delete();
        send_beat(rand_beat(), 1'b1, 1'b0, 3'd0, 4'h2);
        send_beat(rand_beat(), 1'b1, 1'b1, 3'd0, 4'h4);
        in_idle();
        wait_idle();
        checks += 4;
        if (err_cycles - e0 != 2) begin errors++; $display("FAIL frame_sop_err got %0d cycles exp 2", err_cycles - e0); end
        if (pkt_count !== 16'd1) begin errors++; $display("FAIL frame_pkt_count got %0d exp 1", pkt_count); end
        if (obs_q.size() - base != 16) begin
            errors++; $display("FAIL frame_count got %0d exp 16", obs_q.size() - base);
        end else begin
            if (obs_q[base+7].e !== 1'b0 || obs_q[base+8].s !== 1'b1 || obs_q[base+8].c !== 4'h4) begin
                errors++;
                $display("FAIL frame_resync got eop7=%b sop8=%b ch8=%h exp 0/1/4", obs_q[base+7].e, obs_q[base+8].s, obs_q[base+8].c);
            end
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (obs_q[base+i].d !== exp_q[i].d || obs_q[base+i].s !== exp_q[i].s || obs_q[base+i].e !== exp_q[i].e) begin
                    errors++;
                    $display("FAIL frame_slice[%0d] got %h/%b/%b exp %h/%b/%b", i, obs_q[base+i].d, obs_q[base+i].s,
                             obs_q[base+i].e, exp_q[i].d, exp_q[i].s, exp_q[i].e);
                end
            end
        end
    endtask

    task automatic test_reset_midpacket();
        int base;
        int n;
        base = obs_q.size();
        send_beat(rand_beat(), 1'b1, 1'b0, 3'd0, 4'h9);
        in_idle();
        n = 0;
        @(negedge clock_clk); #1;
        while (obs_q.size() < base + 3 && n < 20) begin
            @(negedge clock_clk); #1;
            n++;
        end
        @(posedge clock_clk); #1;
        reset_reset = 1'b1;
        #1;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", out_valid); end
        if (pkt_count !== 16'd0) begin errors++; $display("FAIL midrst_pkt_count got %0d exp 0", pkt_count); end
        repeat (2) @(posedge clock_clk);
        @(negedge clock_clk);
        reset_reset = 1'b0;
        m_in_pkt = 1'b0; m_pkts = 0;
        exp_q.delete(); exp_le_q.delete();
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", in_ready); end
        repeat (4) @(posedge clock_clk);
        #1;
        checks++;
        if (obs_q.size() - base != 3) begin errors++; $display("FAIL midrst_drop got %0d slices exp 3", obs_q.size() - base); end
        base = obs_q.size();
        send_beat(rand_beat(), 1'b1, 1'b0, 3'd0, 4'hC);
        send_beat(rand_beat(), 1'b0, 1'b1, 3'd2, 4'hC);
        in_idle();
        wait_idle();
        checks += 2;
        if (pkt_count !== 16'd1) begin errors++; $display("FAIL midrst_next_pkt got %0d exp 1", pkt_count); end
        if (obs_q.size() - base != exp_q.size()) begin
            errors++; $display("FAIL midrst_next_count got %0d exp %0d", obs_q.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[base+i].d !== exp_q[i].d || obs_q[base+i].s !== exp_q[i].s ||
                    obs_q[base+i].e !== exp_q[i].e || obs_q[base+i].c !== exp_q[i].c) begin
                    errors++;
                    $display("FAIL midrst_slice[%0d] got %h/%b/%b exp %h/%b/%b", i, obs_q[base+i].d, obs_q[base+i].s,
                             obs_q[base+i].e, exp_q[i].d, exp_q[i].s, exp_q[i].e);
                end
            end
        end
    endtask

    task automatic test_random();
        int base;
        int lbase;
        int e0;
        int me0;
        int s0;
        bit done;
        exp_q.delete(); exp_le_q.delete();
        base = obs_q.size();
        lbase = le_q.size();
        e0 = err_cycles;
        me0 = m_err;
        s0 = stall_viol;
        done = 1'b0;
        fork
            begin
                for (int b = 0; b < 60; b++) begin
                    int r;
                    logic s;
                    r = $urandom_range(0, 99);
                    s = m_in_pkt ? (r < 8) : (r >= 8);
                    send_beat(rand_beat(), s, $urandom_range(0, 2) == 0, EW'($urandom_range(0, 7)),
                              CW'($urandom_range(0, 15)));
                    if ($urandom_range(0, 2) == 0) begin
                        in_idle();
                        repeat ($urandom_range(1, 4)) @(posedge clock_clk);
                        #1;
                    end
                end
                in_idle();
                wait_idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clock_clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        checks += 5;
        if (err_cycles - e0 != m_err - me0) begin
            errors++; $display("FAIL rnd_err got %0d exp %0d", err_cycles - e0, m_err - me0);
        end
        if (pkt_count !== 16'(m_pkts)) begin errors++; $display("FAIL rnd_pkt_count got %0d exp %0d", pkt_count, m_pkts); end
        if (le_pkt_count !== 16'(m_pkts)) begin errors++; $display("FAIL rnd_le_pkt_count got %0d exp %0d", le_pkt_count, m_pkts); end
        if (stall_viol - s0 != 0) begin errors++; $display("FAIL rnd_stability got %0d exp 0", stall_viol - s0); end
        if (obs_q.size() - base != exp_q.size() || le_q.size() - lbase != exp_le_q.size()) begin
            errors++;
            $display("FAIL rnd_count got %0d/%0d exp %0d", obs_q.size() - base, le_q.size() - lbase, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[base+i].d !== exp_q[i].d || obs_q[base+i].s !== exp_q[i].s ||
                    obs_q[base+i].e !== exp_q[i].e || obs_q[base+i].c !== exp_q[i].c ||
                    le_q[lbase+i].d !== exp_le_q[i].d || le_q[lbase+i].e !== exp_le_q[i].e) begin
                    errors++;
                    $display("FAIL rnd_slice[%0d] got %h/%b/%b/%h le %h exp %h/%b/%b/%h le %h", i,
                             obs_q[base+i].d, obs_q[base+i].s, obs_q[base+i].e, obs_q[base+i].c, le_q[lbase+i].d,
                             exp_q[i].d, exp_q[i].s, exp_q[i].e, exp_q[i].c, exp_le_q[i].d);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_beat();
        test_empty();
        test_back_to_back();
        test_stall();
        test_framing();
        test_reset_midpacket();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/packet_width_downconverter.md
PACKET_WIDTH_DOWNCONVERTER -- requirements
Module: packet_width_downconverter

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 256, input beat width in bits.
REQ-002 SHALL have parameter OUT_WIDTH, default 32, output slice width in bits.
REQ-003 SHALL have parameter BIG_ENDIAN, default 1; 1 means the MS slice goes first, 0 means the LS slice goes first.
REQ-004 SHALL have parameter CHANNEL_WIDTH, default 4, sideband channel width.
REQ-005 SHALL derive RATIO = IN_WIDTH/OUT_WIDTH and EMPTY_WIDTH = clog2(RATIO); elaboration SHALL fail if IN_WIDTH mod OUT_WIDTH != 0 or RATIO < 2.
REQ-006 SHALL have ports (name, direction, width, meaning):
- clock_clk, in, 1: clock.
- reset_reset, in, 1: reset, asynchronous, active-high.
- asi_in0_data, in, IN_WIDTH: input beat.
- asi_in0_valid, in, 1: input valid.
- asi_in0_ready, out, 1: input ready.
- asi_in0_startofpacket, in, 1: first beat of packet.
- asi_in0_endofpacket, in, 1: last beat of packet.
- asi_in0_empty, in, EMPTY_WIDTH: unused trailing slices on an EOP beat.
- asi_in0_channel, in, CHANNEL_WIDTH: packet channel.
- aso_out0_data, out, OUT_WIDTH: output slice.
- aso_out0_valid, out, 1: output valid.
- aso_out0_ready, in, 1: output ready.
- aso_out0_startofpacket, out, 1: first slice of packet.
- aso_out0_endofpacket, out, 1: last slice of packet.
- aso_out0_channel, out, CHANNEL_WIDTH: channel of the current slice.
- stat_pkt_count, out, 16: completed packets, wraps modulo 2^16.
- stat_err_framing, out, 1: one-cycle pulse on a framing error.

Function
REQ-007 SHALL hold one input beat in a buffer register plus a slice index, count target, sop/eop/channel flags and an in_packet flag.
REQ-008 SHALL run two states:
- EMPTY: buffer holds no data.
- SERIALISE: buffer holds a beat with slices left to emit.
REQ-009 SHALL drive asi_in0_ready = (state==EMPTY) or (aso_out0_valid and aso_out0_ready and current slice is last of beat), giving zero-bubble back-to-back beats.
REQ-010 SHALL accept an input beat on valid and ready at edge k; the first slice SHALL be valid from cycle k+1 (latency 1).
REQ-011 SHALL emit RATIO slices for a non-EOP beat and RATIO - empty slices for an EOP beat.
REQ-012 SHALL ignore asi_in0_empty on non-EOP beats and SHALL treat an EOP-beat empty >= RATIO as RATIO-1 (one slice emitted).
REQ-013 SHALL order slices as follows: with BIG_ENDIAN=1, slice i = data[IN_WIDTH-1-i*OUT_WIDTH -: OUT_WIDTH]; with BIG_ENDIAN=0, slice i = data[i*OUT_WIDTH +: OUT_WIDTH].
REQ-014 SHALL assert aso_out0_startofpacket only on slice 0 of an SOP beat, and aso_out0_endofpacket only on the last emitted slice of an EOP beat; a beat with both set SHALL produce both markers.
REQ-015 SHALL advance the slice index only on aso_out0_valid and aso_out0_ready; while valid and !ready, data, markers and channel SHALL stay stable.
REQ-016 SHALL hold aso_out0_channel at the channel latched with the beat, constant over all of the beat's slices.
REQ-017 SHALL accept and discard, with no output, a beat without SOP while in_packet=0, and SHALL pulse stat_err_framing.
REQ-018 SHALL, on an SOP beat while in_packet=1, pulse stat_err_framing, start a new packet and emit it normally; no synthetic EOP SHALL be inserted.
REQ-019 SHALL set in_packet on acceptance of an SOP beat and clear it on acceptance of an EOP beat.
REQ-020 SHALL increment stat_pkt_count on each output EOP handshake.
REQ-021 SHALL, when a new beat is accepted in the same cycle the last slice fires, reload buffer and index with no idle cycle.

Reset
REQ-022 SHALL, while reset_reset=1, clear to 0: state (EMPTY), buffer, index, in_packet, aso_out0_valid, aso_out0_data, startofpacket, endofpacket, channel, stat_pkt_count and stat_err_framing.
REQ-023 SHALL, on reset mid-packet, drop the buffered beat with no EOP emitted; asi_in0_ready SHALL be 1 in the first cycle after deassertion.

Verification
REQ-024 SHALL cover these scenarios at IN_WIDTH=256, OUT_WIDTH=32, BIG_ENDIAN=1, out ready held at 1:
- Single beat SOP+EOP, empty=0, data = words 0x7..0x0 (MS to LS) -> 8 slices 0x7..0x0; SOP on slice 1, EOP on slice 8; stat_pkt_count=1.
- EOP beat with empty=5 -> exactly 3 slices, EOP on the 3rd; empty=9-style overflow is unreachable (3-bit), and empty=7 -> 1 slice.
- 3-beat packet, input always valid -> 24 consecutive valid cycles, no bubbles; ready high once every 8 cycles.
- Output ready toggling 1,0,1,0 -> every slice delivered once, in order, stable while stalled; total 16 cycles for 8 slices.
- Non-SOP beat after reset -> no output, stat_err_framing high exactly 1 cycle; SOP inside packet -> err pulse plus new SOP output.
- Reset asserted after slice 3 of 8 -> valid low immediately, ready=1 after release, next packet correct; BIG_ENDIAN=0 run emits 0x0 first.
